// File: rtl/write_mem_fetch.sv
// Program-memory fetch and host write port for the write engine.
// Ports: clock/reset (sync, active-high); host_* load/write/read
//   strobes and data; running/maddr_inc from the engine; mdat and
//   mem_ready to the engine; ram_* to a 1-cycle-latency sync RAM;
//   addr, wrap_flag, lock_err status.
// Optional feature: define MEM_READBACK_EN for host readback via
//   host_rd/host_rdata (host_rdata is tied 0 without it).
module write_mem_fetch #(
  parameter int ADDR_BITS = 14
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 host_addr_load,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic                 host_wr,
  input  logic [7:0]           host_wdata,
  input  logic                 host_rd,
  output logic [7:0]           host_rdata,
  input  logic                 running,
  input  logic                 maddr_inc,
  output logic [7:0]           mdat,
  output logic                 mem_ready,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [7:0]           ram_wdata,
  output logic                 ram_we,
  input  logic [7:0]           ram_rdata,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 wrap_flag,
  output logic                 lock_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SETTLE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 wrap_q, wrap_d;
  logic                 lock_q, lock_d;

  logic rd_req;
  logic strobe;
  logic do_load;
  logic do_wr;
  logic do_rd;
  logic do_inc;
  logic addr_chg;
  logic at_max;

`ifdef MEM_READBACK_EN
  assign rd_req = host_rd;
`else
  logic unused_host_rd;
  assign unused_host_rd = host_rd;
  assign rd_req = 1'b0;
`endif

  // Host strobes only act while the engine is stopped.
  assign strobe  = host_addr_load | host_wr | rd_req;
  assign do_load = ~running & host_addr_load;
  assign do_wr   = ~running & ~host_addr_load & host_wr;
  assign do_rd   = ~running & ~host_addr_load
                 & ~host_wr & rd_req;
  // Host write/read and an engine step merge into one increment.
  assign do_inc  = ~do_load & (do_wr | do_rd | maddr_inc);
  assign addr_chg = do_load | do_inc;
  assign at_max   = &addr_q;

  always_comb begin
    addr_d = addr_q;
    wrap_d = wrap_q;
    lock_d = lock_q;
    if (do_load) begin
      addr_d = host_addr;
      wrap_d = 1'b0;
      lock_d = 1'b0;
    end else if (do_inc) begin
      addr_d = addr_q + 1'b1;
      if (at_max) begin
        wrap_d = 1'b1;
      end
    end
    if (running && strobe) begin
      lock_d = 1'b1;
    end
  end

  // SETTLE covers the cycle in which the RAM has not yet
  // registered the new address.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (addr_chg) begin
          state_d = S_SETTLE;
        end else if (running) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (addr_chg) begin
          state_d = S_SETTLE;
        end else if (!running) begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (addr_chg) begin
          state_d = S_SETTLE;
        end else if (running) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_SETTLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_SETTLE;
      addr_q  <= '0;
      wrap_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wrap_q  <= wrap_d;
      lock_q  <= lock_d;
    end
  end

`ifdef MEM_READBACK_EN
  // The RAM samples addr on the read edge; its data is captured
  // one edge later, so back-to-back reads stay aligned.
  logic       rd_pend_q, rd_pend_d;
  logic [7:0] rdata_q, rdata_d;

  always_comb begin
    rd_pend_d = do_rd;
    rdata_d   = rdata_q;
    if (rd_pend_q) begin
      rdata_d = ram_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rdata_q   <= rdata_d;
    end
  end

  assign host_rdata = rdata_q;
`else
  assign host_rdata = '0;
`endif

  // Reset gates the write so an abandoned run never commits.
  assign ram_we    = do_wr & ~reset;
  assign ram_wdata = host_wdata;
  assign ram_addr  = addr_q;
  assign mdat      = ram_rdata;
  assign mem_ready = (state_q != S_SETTLE);
  assign addr      = addr_q;
  assign wrap_flag = wrap_q;
  assign lock_err  = lock_q;

endmodule
